// File: rtl/stitch_fpu_issue.sv
// stitch_fpu_issue
//   Issue stage in front of the FPU scoreboard (stitch_sb). A decoded FP op is
//   checked against the scoreboard for RAW/WAW hazards on its used sources and
//   its destination. When the op issues, its rd is pushed into the scoreboard
//   and the op, rd and allocated one-hot tag are held in a 1-entry output
//   register towards the FPU. FPU writeback tags are forwarded to the scoreboard
//   pop port. A flush drops the held op and returns its tag; if a writeback is
//   using the pop port in that cycle, the tag is returned later from RETURN.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   in_valid_i/in_ready_o        upstream op handshake
//   in_op_i, in_rs_i, in_rs_used_i, in_rd_i   op payload, sources, used flags, dest
//   sb_push_addr_o/valid_o       scoreboard allocate
//   sb_entry_index_i             one-hot free tag offered by the scoreboard
//   sb_test_addr_o               {rd,rs3,rs2,rs1} hazard test addresses
//   sb_test_present_i            per-test-address hit
//   sb_full_i                    scoreboard has no free entry
//   sb_pop_index_o/valid_o       scoreboard free
//   out_valid_o/out_ready_i      FPU handshake
//   out_op_o, out_tag_o, out_rd_o  held op, tag and rd
//   wb_valid_i, wb_tag_i         FPU writeback completion
//   flush_i                      drop held op, block input this cycle
//
// Configuration
//   STITCH_FPU_ISSUE_PERF_EN     adds saturating stall counters
//                                stall_hazard_cnt_o / stall_full_cnt_o.

module stitch_fpu_issue #(
  parameter int AddrWidth = 5,
  parameter int Depth     = 4,
  parameter int OpWidth   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [OpWidth-1:0]     in_op_i,
  input  logic [3*AddrWidth-1:0] in_rs_i,
  input  logic [2:0]             in_rs_used_i,
  input  logic [AddrWidth-1:0]   in_rd_i,
  output logic [AddrWidth-1:0]   sb_push_addr_o,
  output logic                   sb_push_valid_o,
  input  logic [Depth-1:0]       sb_entry_index_i,
  output logic [4*AddrWidth-1:0] sb_test_addr_o,
  input  logic [3:0]             sb_test_present_i,
  input  logic                   sb_full_i,
  output logic [Depth-1:0]       sb_pop_index_o,
  output logic                   sb_pop_valid_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OpWidth-1:0]     out_op_o,
  output logic [Depth-1:0]       out_tag_o,
  output logic [AddrWidth-1:0]   out_rd_o,
  input  logic                   wb_valid_i,
  input  logic [Depth-1:0]       wb_tag_i,
`ifdef STITCH_FPU_ISSUE_PERF_EN
  output logic [31:0]            stall_hazard_cnt_o,
  output logic [31:0]            stall_full_cnt_o,
`endif
  input  logic                   flush_i
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OpWidth-1:0]   op_q, op_d;
  logic [Depth-1:0]     tag_q, tag_d;
  logic [AddrWidth-1:0] rd_q, rd_d;

  logic hazard;
  logic slot_free;
  logic ready;
  logic issue;
  logic handshake;
  logic flush_pop;

  always_comb begin
    // rd is always tested (WAW); sources only when actually used (RAW).
    hazard    = (|(sb_test_present_i[2:0] & in_rs_used_i)) | sb_test_present_i[3];
    slot_free = (state_q == ST_EMPTY) ||
                ((state_q == ST_FULL) && out_ready_i && !flush_i);
    ready     = !hazard && !sb_full_i && slot_free && !flush_i &&
                (state_q != ST_RETURN) && !rst_i;
    issue     = in_valid_i && ready;
    handshake = (state_q == ST_FULL) && out_ready_i && !flush_i;
    // The held tag is returned by flush only when writeback is not using the pop port.
    flush_pop = !wb_valid_i &&
                (((state_q == ST_FULL) && flush_i) || (state_q == ST_RETURN));

    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    rd_d    = rd_q;

    if (issue) begin
      op_d  = in_op_i;
      tag_d = sb_entry_index_i;
      rd_d  = in_rd_i;
    end

    case (state_q)
      ST_EMPTY: begin
        if (issue) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (flush_i) begin
          state_d = wb_valid_i ? ST_RETURN : ST_EMPTY;
        end else if (handshake) begin
          state_d = issue ? ST_FULL : ST_EMPTY;
        end
      end
      ST_RETURN: begin
        // tag_q still holds the dropped op's tag: nothing can issue here.
        if (!wb_valid_i) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      op_q    <= '0;
      tag_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
    end
  end

  assign in_ready_o      = ready;
  assign sb_push_valid_o = issue;
  assign sb_push_addr_o  = in_rd_i;
  assign sb_test_addr_o  = {in_rd_i, in_rs_i};

  // Writeback owns the pop port when both want it.
  assign sb_pop_valid_o  = (wb_valid_i || flush_pop) && !rst_i;
  assign sb_pop_index_o  = wb_valid_i ? wb_tag_i : tag_q;

  assign out_valid_o     = (state_q == ST_FULL) && !flush_i;
  assign out_op_o        = op_q;
  assign out_tag_o       = tag_q;
  assign out_rd_o        = rd_q;

`ifdef STITCH_FPU_ISSUE_PERF_EN
  logic [31:0] hz_cnt_q, hz_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;

  always_comb begin
    hz_cnt_d = hz_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (in_valid_i && hazard && (hz_cnt_q != 32'hFFFF_FFFF))
      hz_cnt_d = hz_cnt_q + 32'd1;
    if (in_valid_i && !hazard && sb_full_i && (fl_cnt_q != 32'hFFFF_FFFF))
      fl_cnt_d = fl_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hz_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      hz_cnt_q <= hz_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign stall_hazard_cnt_o = hz_cnt_q;
  assign stall_full_cnt_o   = fl_cnt_q;
`endif

endmodule

// File: tb/tb_stitch_fpu_issue.sv
module tb_stitch_fpu_issue;

  localparam int AW = 5;
  localparam int DP = 4;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_op;
  logic [3*AW-1:0] in_rs;
  logic [2:0]    in_rs_used;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] push_addr;
  logic          push_valid;
  logic [DP-1:0] entry_index;
  logic [4*AW-1:0] test_addr;
  logic [3:0]    test_present;
  logic          sb_full;
  logic [DP-1:0] pop_index;
  logic          pop_valid;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_op;
  logic [DP-1:0] out_tag;
  logic [AW-1:0] out_rd;
  logic          wb_valid;
  logic [DP-1:0] wb_tag;
  logic          flush;
`ifdef STITCH_FPU_ISSUE_PERF_EN
  logic [31:0]   hz_cnt;
  logic [31:0]   fl_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stitch_fpu_issue #(.AddrWidth(AW), .Depth(DP), .OpWidth(OW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
    .in_rs_i(in_rs), .in_rs_used_i(in_rs_used), .in_rd_i(in_rd),
    .sb_push_addr_o(push_addr), .sb_push_valid_o(push_valid),
    .sb_entry_index_i(entry_index), .sb_test_addr_o(test_addr),
    .sb_test_present_i(test_present), .sb_full_i(sb_full),
    .sb_pop_index_o(pop_index), .sb_pop_valid_o(pop_valid),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_op_o(out_op), .out_tag_o(out_tag), .out_rd_o(out_rd),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
`ifdef STITCH_FPU_ISSUE_PERF_EN
    .stall_hazard_cnt_o(hz_cnt), .stall_full_cnt_o(fl_cnt),
`endif
    .flush_i(flush)
  );

  // Advance one clock; inputs change 1ns after the edge, checks are made 2ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = '0; in_rs = '0; in_rs_used = '0; in_rd = '0;
    entry_index = '0; test_present = '0; sb_full = 0; out_ready = 0;
    wb_valid = 0; wb_tag = '0; flush = 0;
  endtask

  task automatic load_op(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                         input logic [DP-1:0] tag);
    in_valid = 1; in_op = op; in_rd = rd; entry_index = tag;
    in_rs_used = '0; test_present = '0; sb_full = 0; flush = 0; wb_valid = 0;
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    in_valid = 1; in_rd = 5'd9; entry_index = 4'b0001;
    settle();
    checks++; if (push_valid !== 1'b0) begin errors++; $display("FAIL reset_push got %b exp 0", push_valid); end
    step(); step();
    rst = 0; in_valid = 0;
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_op !== '0 || out_tag !== '0 || out_rd !== '0) begin errors++; $display("FAIL reset_out_regs got %h/%b/%0d exp 0", out_op, out_tag, out_rd); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop got %b exp 0", pop_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_issue_and_hazard();
    idle_inputs();
    in_valid = 1; in_op = 32'h0000_00A5; in_rd = 5'd3; entry_index = 4'b0010;
    in_rs = {5'd1, 5'd2, 5'd4};
    settle();
    checks++; if (push_valid !== 1'b1 || push_addr !== 5'd3) begin errors++; $display("FAIL issue_push got %b/%0d exp 1/3", push_valid, push_addr); end
    checks++; if (test_addr !== {5'd3, 5'd1, 5'd2, 5'd4}) begin errors++; $display("FAIL issue_test_addr got %h exp %h", test_addr, {5'd3, 5'd1, 5'd2, 5'd4}); end
    step();
    // Dependent op: rs1 = 3 hits the just-pushed entry.
    in_op = 32'h0000_00B6; in_rs = {5'd0, 5'd0, 5'd3}; in_rs_used = 3'b001; in_rd = 5'd6;
    entry_index = 4'b0100; test_present = 4'b0001; out_ready = 1;
    settle();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'b0010 || out_rd !== 5'd3 || out_op !== 32'hA5) begin errors++; $display("FAIL issue_out got %b/%b/%0d/%h exp 1/0010/3/a5", out_valid, out_tag, out_rd, out_op); end
    checks++; if (in_ready !== 1'b0 || push_valid !== 1'b0) begin errors++; $display("FAIL raw_stall got ready %b push %b exp 0/0", in_ready, push_valid); end
    step();
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall2 got out_valid %b ready %b exp 0/0", out_valid, in_ready); end
    // Hit on an unused source is not a hazard.
    test_present = 4'b0010;
    settle();
    checks++; if (in_ready !== 1'b1 || push_valid !== 1'b1) begin errors++; $display("FAIL unused_src got ready %b push %b exp 1/1", in_ready, push_valid); end
    // rd is always tested.
    test_present = 4'b1000;
    wb_valid = 1; wb_tag = 4'b0010;
    settle();
    checks++; if (in_ready !== 1'b0 || pop_valid !== 1'b1 || pop_index !== 4'b0010) begin errors++; $display("FAIL waw_wb got ready %b pop %b/%b exp 0/1/0010", in_ready, pop_valid, pop_index); end
    step();
    wb_valid = 0; test_present = 4'b0000;
    settle();
    checks++; if (push_valid !== 1'b1 || push_addr !== 5'd6) begin errors++; $display("FAIL raw_release got %b/%0d exp 1/6", push_valid, push_addr); end
    step();
    in_valid = 0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_op !== 32'hB6 || out_tag !== 4'b0100) begin errors++; $display("FAIL raw_out got %b/%h/%b exp 1/b6/0100", out_valid, out_op, out_tag); end
    drain();
  endtask

  task automatic test_hold();
    idle_inputs();
    load_op(32'hDEAD_BEEF, 5'd12, 4'b1000);
    in_valid = 1; in_op = 32'h1111_1111; in_rd = 5'd7; entry_index = 4'b0001;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (out_valid !== 1'b1 || out_op !== 32'hDEAD_BEEF || out_tag !== 4'b1000 ||
          in_ready !== 1'b0 || push_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v%b op %h tag %b rdy %b push %b exp 1/deadbeef/1000/0/0",
                 i, out_valid, out_op, out_tag, in_ready, push_valid);
      end
      step();
    end
    drain();
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_flush_return();
    idle_inputs();
    load_op(32'h0000_0044, 5'd4, 4'b0100);
    flush = 1; wb_valid = 1; wb_tag = 4'b0001; out_ready = 1;
    in_valid = 1; in_rd = 5'd8; entry_index = 4'b0010;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || push_valid !== 1'b0) begin errors++; $display("FAIL flush_block got v%b r%b p%b exp 0/0/0", out_valid, in_ready, push_valid); end
    checks++; if (pop_valid !== 1'b1 || pop_index !== 4'b0001) begin errors++; $display("FAIL flush_wb_pop got %b/%b exp 1/0001", pop_valid, pop_index); end
    step();
    flush = 0; wb_tag = 4'b1000;
    settle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || pop_index !== 4'b1000 || pop_valid !== 1'b1) begin errors++; $display("FAIL return_wait got v%b r%b pop %b/%b exp 0/0/1/1000", out_valid, in_ready, pop_valid, pop_index); end
    step();
    wb_valid = 0;
    settle();
    checks++; if (pop_valid !== 1'b1 || pop_index !== 4'b0100 || in_ready !== 1'b0) begin errors++; $display("FAIL return_pop got %b/%b r%b exp 1/0100/0", pop_valid, pop_index, in_ready); end
    step();
    in_valid = 0;
    settle();
    checks++; if (pop_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL return_empty got pop %b r%b v%b exp 0/1/0", pop_valid, in_ready, out_valid); end
  endtask

  task automatic test_flush_simple();
    idle_inputs();
    load_op(32'h0000_0055, 5'd5, 4'b0010);
    flush = 1; out_ready = 1;
    settle();
    checks++; if (out_valid !== 1'b0 || pop_valid !== 1'b1 || pop_index !== 4'b0010) begin errors++; $display("FAIL flush_pop got v%b pop %b/%b exp 0/1/0010", out_valid, pop_valid, pop_index); end
    step();
    flush = 0;
    settle();
    checks++; if (out_valid !== 1'b0 || pop_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got v%b pop %b exp 0/0", out_valid, pop_valid); end
    // flush in EMPTY only blocks input.
    flush = 1; in_valid = 1; in_rd = 5'd2;
    settle();
    checks++; if (push_valid !== 1'b0 || pop_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got push %b pop %b exp 0/0", push_valid, pop_valid); end
    step();
    idle_inputs();
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_state got %b exp 0", out_valid); end
  endtask

  task automatic test_sb_full();
`ifdef STITCH_FPU_ISSUE_PERF_EN
    logic [31:0] fl0, hz0;
`endif
    idle_inputs();
    load_op(32'h0000_0066, 5'd10, 4'b0001);
`ifdef STITCH_FPU_ISSUE_PERF_EN
    fl0 = fl_cnt; hz0 = hz_cnt;
`endif
    in_valid = 1; in_rd = 5'd11; entry_index = 4'b0010; sb_full = 1; out_ready = 1;
    settle();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || push_valid !== 1'b0) begin errors++; $display("FAIL full_drain got v%b r%b p%b exp 1/0/0", out_valid, in_ready, push_valid); end
    step(); step(); step();
    settle();
    checks++; if (out_valid !== 1'b0 || push_valid !== 1'b0) begin errors++; $display("FAIL full_stall got v%b p%b exp 0/0", out_valid, push_valid); end
`ifdef STITCH_FPU_ISSUE_PERF_EN
    checks++; if (fl_cnt !== fl0 + 32'd3 || hz_cnt !== hz0) begin errors++; $display("FAIL perf_cnt got %0d/%0d exp %0d/%0d", fl_cnt, hz_cnt, fl0 + 32'd3, hz0); end
`endif
    sb_full = 0;
    settle();
    checks++; if (push_valid !== 1'b1) begin errors++; $display("FAIL full_release got %b exp 1", push_valid); end
    step();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] tags [8];
    tags = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    idle_inputs();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_op = 32'd100 + 32'(i); in_rd = 5'(i + 16); entry_index = tags[i];
      settle();
      checks++;
      if (push_valid !== 1'b1 || push_addr !== 5'(i + 16)) begin
        errors++; $display("FAIL stream_push_%0d got %b/%0d exp 1/%0d", i, push_valid, push_addr, i + 16);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_op !== 32'd100 + 32'(i - 1) || out_tag !== tags[i-1]) begin
          errors++; $display("FAIL stream_out_%0d got %b/%0d/%b exp 1/%0d/%b", i, out_valid, out_op, out_tag, 99 + i, tags[i-1]);
        end
      end
      step();
    end
    in_valid = 0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_op !== 32'd107 || out_rd !== 5'd23) begin errors++; $display("FAIL stream_last got %b/%0d/%0d exp 1/107/23", out_valid, out_op, out_rd); end
    drain();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    load_op(32'h0000_0077, 5'd1, 4'b0100);
    rst = 1; flush = 1;
    settle();
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pop got %b exp 0", pop_valid); end
    step();
    rst = 0; flush = 0;
    settle();
    checks++; if (out_valid !== 1'b0 || out_tag !== 4'b0000 || pop_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got v%b tag %b pop %b exp 0/0000/0", out_valid, out_tag, pop_valid); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_issue_and_hazard();
    test_hold();
    test_flush_return();
    test_flush_simple();
    test_sb_full();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
